// File: rtl/store_mon_pkg.sv
// store_mon_pkg: shared types and constants for the store_monitor block.
//   state_e      - checker FSM states
//   FAIL_*       - fail_code encodings
//   STORE_CNT_W  - width of the saturating store counter
package store_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_MISMATCH = 2'd1;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd2;

  localparam int unsigned STORE_CNT_W = 16;

endpackage

// File: rtl/store_mon_timer.sv
// store_mon_timer: run watchdog; clear/enable up-counter with terminal-count flag.
// Ports:
//   clk_i, rst_ni - clock, async active-low reset
//   clr_i         - synchronous clear (wins over enable)
//   en_i          - count enable
//   tc_c_o        - combinational: enabled and count == TIMEOUT_CYC-1
module store_mon_timer
  import store_mon_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_c_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Wrap past TC is harmless: the FSM leaves RUN (dropping en_i) on TC.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_c_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/store_monitor.sv
// store_monitor: checks the core's store stream against a programmable table of
// expected (address, data) pairs, with a scratch-address filter and a watchdog.
// Ports:
//   clk, reset_n                    - clock, async active-low reset
//   exp_wr_en/exp_idx/exp_addr/data - table load (accepted in IDLE with start low)
//   start                           - begin / restart a run
//   mem_write/data_adr/write_data   - tapped core store port
//   busy, done, pass, fail_code     - run status
//   match_cnt, store_cnt            - progress counters
//   fail_addr, fail_data            - offending store (0 on timeout)
// Build option: define STORE_MON_OOO_EN for out-of-order matching (per-entry
// matched mask); otherwise entries must match strictly in index order.
module store_monitor
  import store_mon_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_EXP     = 4,
  parameter logic [ADDR_W-1:0] IGNORE_ADDR = ADDR_W'(96),
  parameter int unsigned TIMEOUT_CYC = 1024,
  localparam int unsigned IDX_W  = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int unsigned MCNT_W = $clog2(NUM_EXP + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   exp_wr_en,
  input  logic [IDX_W-1:0]       exp_idx,
  input  logic [ADDR_W-1:0]      exp_addr,
  input  logic [DATA_W-1:0]      exp_data,
  input  logic                   start,
  input  logic                   mem_write,
  input  logic [ADDR_W-1:0]      data_adr,
  input  logic [DATA_W-1:0]      write_data,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [1:0]             fail_code,
  output logic [MCNT_W-1:0]      match_cnt,
  output logic [STORE_CNT_W-1:0] store_cnt,
  output logic [ADDR_W-1:0]      fail_addr,
  output logic [DATA_W-1:0]      fail_data
);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      tbl_addr_q [NUM_EXP];
  logic [DATA_W-1:0]      tbl_data_q [NUM_EXP];
  logic [MCNT_W-1:0]      match_q, match_d;
  logic [STORE_CNT_W-1:0] store_q, store_d;
  logic [1:0]             code_q, code_d;
  logic [ADDR_W-1:0]      faddr_q, faddr_d;
  logic [DATA_W-1:0]      fdata_q, fdata_d;
  logic                   busy_q, done_q, pass_q;
  logic                   enter_run_c, tbl_we_c, ignore_c, hit_c, last_c, tc_c;
`ifdef STORE_MON_OOO_EN
  logic [NUM_EXP-1:0]     mask_q, mask_d, hit_oh_c;
  logic                   found_c;
`else
  logic [IDX_W-1:0]       ptr_q, ptr_d;
`endif

  store_mon_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (enter_run_c),
    .en_i   (state_q == RUN),
    .tc_c_o (tc_c)
  );

  // Expected-store table: loadable only while idle and not starting.
  assign tbl_we_c = exp_wr_en && !start && (state_q == IDLE) && (32'(exp_idx) < NUM_EXP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        tbl_addr_q[i] <= '0;
        tbl_data_q[i] <= '0;
      end
    end else if (tbl_we_c) begin
      tbl_addr_q[exp_idx] <= exp_addr;
      tbl_data_q[exp_idx] <= exp_data;
    end
  end

  assign ignore_c = (data_adr == IGNORE_ADDR);

`ifdef STORE_MON_OOO_EN
  // Lowest-index unmatched entry equal to the current store.
  always_comb begin
    hit_oh_c = '0;
    found_c  = 1'b0;
    for (int i = 0; i < NUM_EXP; i++) begin
      if (!found_c && !mask_q[i] && (tbl_addr_q[i] == data_adr) &&
          (tbl_data_q[i] == write_data)) begin
        hit_oh_c[i] = 1'b1;
        found_c     = 1'b1;
      end
    end
    hit_c  = found_c;
    last_c = &(mask_q | hit_oh_c);
  end
`else
  assign hit_c  = (tbl_addr_q[ptr_q] == data_adr) && (tbl_data_q[ptr_q] == write_data);
  assign last_c = (ptr_q == IDX_W'(NUM_EXP - 1));
`endif

  // Next-state: run control, store comparison, watchdog.
  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    store_d     = store_q;
    code_d      = code_q;
    faddr_d     = faddr_q;
    fdata_d     = fdata_q;
    enter_run_c = 1'b0;
`ifdef STORE_MON_OOO_EN
    mask_d      = mask_q;
`else
    ptr_d       = ptr_q;
`endif
    unique case (state_q)
      RUN: begin
        if (start) begin
          enter_run_c = 1'b1;
        end else begin
          if (mem_write) begin
            store_d = (store_q == '1) ? store_q : store_q + STORE_CNT_W'(1);
            if (!ignore_c) begin
              if (hit_c) begin
                match_d = match_q + MCNT_W'(1);
`ifdef STORE_MON_OOO_EN
                mask_d  = mask_q | hit_oh_c;
`else
                ptr_d   = ptr_q + IDX_W'(1);
`endif
                if (last_c) state_d = PASS;
              end else begin
                state_d = FAIL;
                code_d  = FAIL_MISMATCH;
                faddr_d = data_adr;
                fdata_d = write_data;
              end
            end
          end
          // A deciding store in the terminal cycle takes priority over timeout.
          if ((state_d == RUN) && tc_c) begin
            state_d = FAIL;
            code_d  = FAIL_TIMEOUT;
          end
        end
      end
      IDLE, PASS, FAIL: begin
        if (start) enter_run_c = 1'b1;
      end
      default: ;
    endcase
    if (enter_run_c) begin
      state_d = RUN;
      match_d = '0;
      store_d = '0;
      code_d  = FAIL_NONE;
      faddr_d = '0;
      fdata_d = '0;
`ifdef STORE_MON_OOO_EN
      mask_d  = '0;
`else
      ptr_d   = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      match_q <= '0;
      store_q <= '0;
      code_q  <= FAIL_NONE;
      faddr_q <= '0;
      fdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef STORE_MON_OOO_EN
      mask_q  <= '0;
`else
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      store_q <= store_d;
      code_q  <= code_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == PASS) || (state_d == FAIL);
      pass_q  <= (state_d == PASS);
`ifdef STORE_MON_OOO_EN
      mask_q  <= mask_d;
`else
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = code_q;
  assign match_cnt = match_q;
  assign store_cnt = store_q;
  assign fail_addr = faddr_q;
  assign fail_data = fdata_q;

endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: directed + randomized checks of store_monitor against an
// outcome-level reference model of a run (per-cycle output prediction).
module tb_store_monitor;

  localparam int unsigned NUM_EXP     = 4;
  localparam int unsigned TIMEOUT_CYC = 1024;
  localparam logic [31:0] IGN         = 32'd96;

  logic        clk = 1'b0;
  logic        reset_n, exp_wr_en, start, mem_write;
  logic [1:0]  exp_idx;
  logic [31:0] exp_addr, exp_data, data_adr, write_data;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [2:0]  match_cnt;
  logic [15:0] store_cnt;
  logic [31:0] fail_addr, fail_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_monitor dut (
    .clk(clk), .reset_n(reset_n), .exp_wr_en(exp_wr_en), .exp_idx(exp_idx),
    .exp_addr(exp_addr), .exp_data(exp_data), .start(start), .mem_write(mem_write),
    .data_adr(data_adr), .write_data(write_data), .busy(busy), .done(done),
    .pass(pass), .fail_code(fail_code), .match_cnt(match_cnt), .store_cnt(store_cnt),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  // Model table and per-cycle stimulus of the current run (entry 0 = start).
  logic [31:0] mt_addr [NUM_EXP];
  logic [31:0] mt_data [NUM_EXP];
  bit          cy_start [$];
  bit          cy_we    [$];
  logic [31:0] cy_addr  [$];
  logic [31:0] cy_data  [$];

  bit          m_busy, m_done, m_pass;
  int          m_code, m_match, m_cnt;
  logic [31:0] m_faddr, m_fdata;

  // Outcome after the first len cycles of the queued stimulus.
  function automatic void predict(int len);
    int ph, t, hit;
    bit [NUM_EXP-1:0] used;
    ph = 0; t = 0; used = '0;
    m_code = 0; m_match = 0; m_cnt = 0; m_faddr = 0; m_fdata = 0;
    for (int k = 0; k < len; k++) begin
      if (cy_start[k]) begin
        ph = 1; t = 0; used = '0;
        m_code = 0; m_match = 0; m_cnt = 0; m_faddr = 0; m_fdata = 0;
        continue;
      end
      if (ph != 1) continue;
      t++;
      if (cy_we[k]) begin
        if (m_cnt < 65535) m_cnt++;
        if (cy_addr[k] != IGN) begin
          hit = -1;
`ifdef STORE_MON_OOO_EN
          for (int j = NUM_EXP - 1; j >= 0; j--)
            if (!used[j] && mt_addr[j] == cy_addr[k] && mt_data[j] == cy_data[k]) hit = j;
`else
          if (mt_addr[m_match] == cy_addr[k] && mt_data[m_match] == cy_data[k]) hit = m_match;
`endif
          if (hit >= 0) begin
            used[hit] = 1'b1;
            m_match++;
            if (m_match == NUM_EXP) ph = 2;
          end else begin
            ph = 3; m_code = 1; m_faddr = cy_addr[k]; m_fdata = cy_data[k];
          end
        end
      end
      if (ph == 1 && t == TIMEOUT_CYC) begin
        ph = 3; m_code = 2;
      end
    end
    m_busy = (ph == 1);
    m_done = (ph >= 2);
    m_pass = (ph == 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " busy"},      32'(busy),      32'(m_busy));
    chk({tag, " done"},      32'(done),      32'(m_done));
    chk({tag, " pass"},      32'(pass),      32'(m_pass));
    chk({tag, " fail_code"}, 32'(fail_code), 32'(m_code));
    chk({tag, " match_cnt"}, 32'(match_cnt), 32'(m_match));
    chk({tag, " store_cnt"}, 32'(store_cnt), 32'(m_cnt));
    chk({tag, " fail_addr"}, fail_addr,      m_faddr);
    chk({tag, " fail_data"}, fail_data,      m_fdata);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic q_new();
    cy_start.delete(); cy_we.delete(); cy_addr.delete(); cy_data.delete();
    cy_start.push_back(1'b1); cy_we.push_back(1'b0);
    cy_addr.push_back(32'd0); cy_data.push_back(32'd0);
  endtask

  task automatic q_restart();
    cy_start.push_back(1'b1); cy_we.push_back(1'b0);
    cy_addr.push_back(32'd0); cy_data.push_back(32'd0);
  endtask

  task automatic q_idle(input int n);
    for (int i = 0; i < n; i++) begin
      cy_start.push_back(1'b0); cy_we.push_back(1'b0);
      cy_addr.push_back(32'($urandom)); cy_data.push_back(32'($urandom));
    end
  endtask

  task automatic q_st(input logic [31:0] a, input logic [31:0] d);
    cy_start.push_back(1'b0); cy_we.push_back(1'b1);
    cy_addr.push_back(a); cy_data.push_back(d);
  endtask

  // Drive queued cycles; table writes are spammed but must never be taken.
  task automatic run_q(input string tag);
    for (int k = 0; k < cy_we.size(); k++) begin
      start      = cy_start[k];
      mem_write  = cy_we[k];
      data_adr   = cy_addr[k];
      write_data = cy_data[k];
      exp_wr_en  = 1'b1;
      exp_idx    = 2'($urandom);
      exp_addr   = 32'($urandom);
      exp_data   = 32'($urandom);
      tick();
      predict(k + 1);
      check_all(tag);
    end
    start = 1'b0; mem_write = 1'b0; exp_wr_en = 1'b0;
  endtask

  task automatic do_reset();
    start = 1'b0; mem_write = 1'b0; exp_wr_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NUM_EXP; i++) begin
      mt_addr[i] = 32'd0; mt_data[i] = 32'd0;
    end
    cy_start.delete(); cy_we.delete(); cy_addr.delete(); cy_data.delete();
    predict(0);
    check_all("reset");
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
    exp_wr_en = 1'b1; exp_idx = 2'(idx); exp_addr = a; exp_data = d; start = 1'b0;
    tick();
    exp_wr_en = 1'b0;
    mt_addr[idx] = a; mt_data[idx] = d;
  endtask

  task automatic load_default();
    load(0, 32'd100, 32'd25);
    load(1, 32'd104, 32'd7);
    load(2, 32'd108, 32'd3);
    load(3, 32'd112, 32'd9);
  endtask

  initial begin
    reset_n = 1'b0; exp_wr_en = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
    start = 1'b0; mem_write = 1'b0; data_adr = '0; write_data = '0;
    tick();
    do_reset();
    load_default();

    // Full in-order pass with scratch store first, random gaps.
    q_new();
    q_st(32'd96, 32'd0);   q_idle(int'($urandom_range(0, 2)));
    q_st(32'd100, 32'd25); q_idle(int'($urandom_range(0, 2)));
    q_st(32'd104, 32'd7);  q_idle(int'($urandom_range(0, 2)));
    q_st(32'd108, 32'd3);  q_idle(int'($urandom_range(0, 2)));
    q_st(32'd112, 32'd9);  q_idle(3);
    run_q("pass4");
    chk("pass4 pass", 32'(pass), 32'd1);
    chk("pass4 match", 32'(match_cnt), 32'd4);
    chk("pass4 stores", 32'(store_cnt), 32'd5);
    chk("pass4 code", 32'(fail_code), 32'd0);

    // Data mismatch on first entry (restart from PASS).
    q_new(); q_st(32'd100, 32'd26); q_idle(2);
    run_q("mism");
    chk("mism code", 32'(fail_code), 32'd1);
    chk("mism addr", fail_addr, 32'd100);
    chk("mism data", fail_data, 32'd26);
    chk("mism match", 32'(match_cnt), 32'd0);

    // Idle run: watchdog.
    q_new(); q_idle(TIMEOUT_CYC + 6);
    run_q("tmo");
    chk("tmo code", 32'(fail_code), 32'd2);
    chk("tmo addr", fail_addr, 32'd0);

    // Final match exactly in the terminal cycle wins over timeout.
    q_new(); q_st(32'd100, 32'd25); q_st(32'd104, 32'd7); q_st(32'd108, 32'd3);
    q_idle(TIMEOUT_CYC - 4); q_st(32'd112, 32'd9); q_idle(2);
    run_q("tc_pass");
    chk("tc_pass pass", 32'(pass), 32'd1);
    chk("tc_pass code", 32'(fail_code), 32'd0);

    // Mismatch in the terminal cycle reports MISMATCH.
    q_new(); q_st(32'd100, 32'd25); q_st(32'd104, 32'd7); q_st(32'd108, 32'd3);
    q_idle(TIMEOUT_CYC - 4); q_st(32'd112, 32'd8); q_idle(2);
    run_q("tc_mism");
    chk("tc_mism code", 32'(fail_code), 32'd1);

    // One cycle too late: timeout.
    q_new(); q_st(32'd100, 32'd25); q_st(32'd104, 32'd7); q_st(32'd108, 32'd3);
    q_idle(TIMEOUT_CYC - 3); q_st(32'd112, 32'd9); q_idle(2);
    run_q("tc_late");
    chk("tc_late code", 32'(fail_code), 32'd2);

    // Permuted order.
    q_new(); q_st(32'd112, 32'd9); q_st(32'd100, 32'd25); q_st(32'd108, 32'd3);
    q_st(32'd104, 32'd7); q_idle(2);
    run_q("order");
`ifdef STORE_MON_OOO_EN
    chk("order pass", 32'(pass), 32'd1);
`else
    chk("order code", 32'(fail_code), 32'd1);
    chk("order addr", fail_addr, 32'd112);
`endif

    // Restart while running discards progress.
    q_new(); q_st(32'd100, 32'd25); q_st(32'd104, 32'd7); q_restart();
    q_st(32'd100, 32'd25); q_st(32'd104, 32'd7); q_st(32'd108, 32'd3);
    q_st(32'd112, 32'd9); q_idle(2);
    run_q("restart");
    chk("restart stores", 32'(store_cnt), 32'd4);

    // Asynchronous reset mid-run clears everything, including the table.
    q_new(); q_st(32'd100, 32'd25); q_st(32'd104, 32'd7); q_idle(1);
    run_q("pre_rst");
    chk("pre_rst match", 32'(match_cnt), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst done", 32'(done), 32'd0);
    chk("arst match", 32'(match_cnt), 32'd0);
    chk("arst stores", 32'(store_cnt), 32'd0);
    for (int i = 0; i < NUM_EXP; i++) begin
      mt_addr[i] = 32'd0; mt_data[i] = 32'd0;
    end
    tick();
    reset_n = 1'b1;
    tick();
    q_new(); q_st(32'd100, 32'd25); q_idle(2);
    run_q("post_rst");
    chk("post_rst code", 32'(fail_code), 32'd1);
    chk("post_rst addr", fail_addr, 32'd100);

    // Randomized tables and store streams.
    for (int r = 0; r < 8; r++) begin
      int n_st;
      logic [31:0] a, d;
      do_reset();
      for (int i = 0; i < NUM_EXP; i++) load(i, 32'($urandom) | 32'h1000, 32'($urandom));
      q_new();
      n_st = (r % 3 == 2) ? NUM_EXP - 1 : NUM_EXP;
      for (int j = 0; j < n_st; j++) begin
        q_idle(int'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0) q_st(IGN, 32'($urandom));
        a = mt_addr[j]; d = mt_data[j];
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 0) a[$urandom_range(0, 31)] ^= 1'b1;
          else d[$urandom_range(0, 31)] ^= 1'b1;
        end
        q_st(a, d);
      end
      q_idle(3);
      run_q("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_monitor.md
Name: store_monitor

Overview:
- Synthesizable, parametrised store-stream checker; generalises the single-store pass/fail check used around the pipelined core's `top` into a reusable block.
- Taps the core's data-memory write port (mem_write, data_adr, write_data).
- Compares stores against a programmable table of NUM_EXP expected (address, data) pairs; filters a scratch address; enforces a watchdog.
- Reports pass/fail with diagnostics. Used in FPGA self-test and in benches.

Parameters:
- ADDR_W, 32, store address width
- DATA_W, 32, store data width
- NUM_EXP, 4, number of expected-store table entries (1..16)
- IGNORE_ADDR, 96, scratch address whose stores are counted but never checked
- TIMEOUT_CYC, 1024, cycles allowed in RUN before timeout failure (>=1)

Ports:
- clk  in  1  clock, rising-edge
- reset_n  in  1  asynchronous active-low reset
- exp_wr_en  in  1  table write strobe (IDLE only)
- exp_idx  in  clog2(NUM_EXP)  table entry index
- exp_addr  in  ADDR_W  expected address
- exp_data  in  DATA_W  expected data
- start  in  1  one-cycle pulse: begin or restart a check run
- mem_write  in  1  core store strobe
- data_adr  in  ADDR_W  core store address
- write_data  in  DATA_W  core store data
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS only
- fail_code  out  2  0 NONE, 1 MISMATCH, 2 TIMEOUT, 3 reserved
- match_cnt  out  clog2(NUM_EXP+1)  expected entries matched
- store_cnt  out  16  total stores seen in RUN, ignored ones included; saturates at 0xFFFF
- fail_addr  out  ADDR_W  address of offending store; 0 on timeout
- fail_data  out  DATA_W  data of offending store; 0 on timeout

Behaviour:
- Reset is asynchronous on reset_n low. It is the only asynchronous path.
  - State -> IDLE.
  - Table, counters, fail_addr and fail_data -> 0.
  - fail_code -> NONE; busy, done and pass -> 0.
- Reset mid-run aborts immediately; no result is retained.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: match of the final entry -> PASS; mismatch -> FAIL(MISMATCH); timer reaches TIMEOUT_CYC -> FAIL(TIMEOUT).
  - PASS / FAIL: hold until start -> RUN (restart).
- Entering RUN clears ptr, match_cnt, store_cnt, timer, fail_addr, fail_data and fail_code. The table is retained.
- Table writes:
  - Accepted on exp_wr_en only in IDLE with start low.
  - Ignored in RUN, PASS and FAIL, and when start is high in the same cycle.
  - exp_idx >= NUM_EXP is ignored.
- Store sampling:
  - Sampled on the rising clk edge when mem_write=1 and in RUN. Stores outside RUN are ignored.
  - data_adr == IGNORE_ADDR: store_cnt++ only.
  - Otherwise compare the store with entry[ptr]:
    - Full address and data equality: ptr++ and match_cnt++. If this was entry NUM_EXP-1, go to PASS next cycle.
    - Any inequality: go to FAIL(MISMATCH); latch data_adr into fail_addr and write_data into fail_data.
- Latency: outputs reflect a store one cycle after its sampling edge.
- Timer:
  - Increments every RUN cycle.
  - At count == TIMEOUT_CYC-1, and with no deciding store that cycle, go to FAIL(TIMEOUT).
- Simultaneous events:
  - A deciding store in the timeout cycle wins: PASS or MISMATCH is reported, not TIMEOUT.
  - start in RUN restarts the run; the current store is discarded.
- Arithmetic:
  - store_cnt saturates.
  - match_cnt never exceeds NUM_EXP.
  - Equality compares all ADDR_W/DATA_W bits.

Optional Feature:
- STORE_MON_OOO_EN defined:
  - Out-of-order matching. A non-ignored store matches any not-yet-matched entry with equal address and data. If several entries are equal, the lowest index is taken.
  - A per-entry matched bitmask replaces ptr. PASS when the mask is all ones. MISMATCH when no unmatched entry equals the store.
- Undefined: strict in-order matching as in Behaviour; no bitmask logic is present.

Decomposition:
- store_mon_pkg holds:
  - state enum: IDLE, RUN, PASS, FAIL
  - fail_code constants: FAIL_NONE, FAIL_MISMATCH, FAIL_TIMEOUT
  - STORE_CNT_W = 16
- One sub-module, store_mon_timer: clear/enable counter with a terminal-count flag, parametrised by TIMEOUT_CYC.

Test Plan (defaults unless noted):
- Load {(100,25),(104,7),(108,3),(112,9)}. Start. Drive stores 96:0, 100:25, 104:7, 108:3, 112:9. -> pass=1 the cycle after the 112 store; match_cnt=4; store_cnt=5; fail_code=0.
- Same table. Store 100:26. -> FAIL, fail_code=1, fail_addr=100, fail_data=26, match_cnt=0.
- Start with no stores. -> busy for 1024 cycles, then done=1, fail_code=2, fail_addr=0.
- Store 100:25 in the timeout cycle with NUM_EXP=1. -> pass=1, fail_code=0.
- Pulse reset_n low mid-run after 2 matches. -> immediately IDLE, all outputs 0. Table reads 0: a subsequent run with store 100:25 fails MISMATCH.
- With STORE_MON_OOO_EN: stores 112:9, 100:25, 108:3, 104:7. -> PASS. Without the macro, the same sequence -> FAIL(MISMATCH), fail_addr=112.
